tinysoc_button: RTL and testbench



---
 rtl/tinysoc_button.sv | 141 ++++++++++++++
 tb/tb_tinysoc_button.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tinysoc_button.sv
// Debounced push-button reader: two-flop synchroniser, hold-time qualification,
// clean level plus press/release/long-press strobes and a wrapping press count.
// The release strobe is named `released` because `release` is a reserved word.
module tinysoc_button #(
    parameter int unsigned clk_freq_hz   = 16_000_000,
    parameter int unsigned debounce_ms   = 10,
    parameter int unsigned long_press_ms = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       level,
    output logic       press,
    output logic       released,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int unsigned D      = clk_freq_hz / 1000 * debounce_ms;
    localparam int unsigned L      = clk_freq_hz / 1000 * long_press_ms;
    localparam int unsigned CNT_W  = $clog2(D + 1);
    localparam int unsigned HOLD_W = $clog2(L + 1);

    typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

    state_t              state_q, state_d;
    logic                s1, s2;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic                level_d, press_d, released_d, long_d;
    logic [7:0]          count_d;
    logic                rise, fall;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign hold_inc = hold_q + HOLD_W'(1);

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        level_d    = level;
        press_d    = 1'b0;
        released_d = 1'b0;
        long_d     = 1'b0;
        count_d    = press_count;
        rise       = 1'b0;
        fall       = 1'b0;

        // Hold time accumulates for as long as the debounced level is 1.
        if ((state_q == HIGH || state_q == CHK_LO) && hold_q != HOLD_W'(L)) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_W'(L)) begin
                long_d = 1'b1;
            end
        end

        case (state_q)
            LOW: begin
                if (s2) begin
                    if (D == 1) begin
                        rise = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_d = LOW;
                end else if (cnt_inc == CNT_W'(D)) begin
                    rise = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HIGH: begin
                if (!s2) begin
                    if (D == 1) begin
                        fall = 1'b1;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_LO: begin
                if (s2) begin
                    state_d = HIGH;
                end else if (cnt_inc == CNT_W'(D)) begin
                    fall = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = LOW;
        endcase

        if (rise) begin
            state_d = HIGH;
            level_d = 1'b1;
            press_d = 1'b1;
            count_d = press_count + 8'd1;
            hold_d  = '0;
        end
        if (fall) begin
            state_d    = LOW;
            level_d    = 1'b0;
            released_d = 1'b1;
        end
    end

    // Synchroniser, state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state_q     <= LOW;
            cnt_q       <= '0;
            hold_q      <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            released    <= 1'b0;
            long_press  <= 1'b0;
            press_count <= 8'd0;
        end else begin
            s1          <= btn;
            s2          <= s1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            level       <= level_d;
            press       <= press_d;
            released    <= released_d;
            long_press  <= long_d;
            press_count <= count_d;
        end
    end

endmodule

// File: tb/tb_tinysoc_button.sv
// Bench for tinysoc_button: directed scenarios plus random bounce traffic,
// checked every cycle against a run-length debounce model.
module tb_tinysoc_button;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       level, press, released, long_press;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit hist[$] = '{1'b0, 1'b0};
    bit m_level = 1'b0;
    int m_run   = 0;
    int m_age   = 0;
    bit m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;
    int m_count = 0;

    int press_seen = 0;
    int long_seen  = 0;

    tinysoc_button #(
        .clk_freq_hz  (1000),
        .debounce_ms  (4),
        .long_press_ms(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .level      (level),
        .press      (press),
        .released   (released),
        .long_press (long_press),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: level flips after D consecutive observations (btn seen two edges late)
    // that differ from it; long press once the level has been 1 for L edges.
    task automatic model_edge();
        bit obs;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (rst) begin
            hist    = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_run   = 0;
            m_age   = 0;
            m_count = 0;
        end else begin
            obs = hist[0];
            if (m_level && m_age < L) begin
                m_age++;
                if (m_age == L) m_long = 1'b1;
            end
            if (obs != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = obs;
                    m_run   = 0;
                    if (obs) begin
                        m_press = 1'b1;
                        m_count = (m_count + 1) % 256;
                        m_age   = 0;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            void'(hist.pop_front());
            hist.push_back(btn);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("level",       32'(level),       32'(m_level));
        check("press",       32'(press),       32'(m_press));
        check("release",     32'(released),    32'(m_rel));
        check("long_press",  32'(long_press),  32'(m_long));
        check("press_count", 32'(press_count), 32'(m_count));
        if (press)      press_seen++;
        if (long_press) long_seen++;
    endtask

    // Ticks until the selected strobe appears; lat=-1 if the budget expires.
    task automatic run_until(input int which, input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((which == 0 && press) || (which == 1 && released) || (which == 2 && long_press)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int snap;
        int gap;

        // Reset then idle
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (50) tick();
        check("idle_level", 32'(level), 32'd0);
        check("idle_count", 32'(press_count), 32'd0);

        // Clean press with long press, then release
        btn = 1'b1;
        run_until(0, 30, lat);
        check("press_latency", 32'(lat), 32'(D + 2));
        check("count_after_press", 32'(press_count), 32'd1);
        run_until(2, 40, lat);
        check("long_latency", 32'(lat), 32'(L));
        repeat (8) tick();
        btn = 1'b0;
        run_until(1, 30, lat);
        check("release_latency", 32'(lat), 32'(D + 2));
        check("level_after_release", 32'(level), 32'd0);
        check("long_once", 32'(long_seen), 32'd1);
        repeat (10) tick();

        // Bounce rejection: runs of 3 and 2 highs never qualify
        snap = press_seen;
        btn = 1'b1; repeat (3) tick();
        btn = 1'b0; repeat (1) tick();
        btn = 1'b1; repeat (2) tick();
        btn = 1'b0; repeat (15) tick();
        check("bounce_no_press", 32'(press_seen), 32'(snap));
        check("bounce_level", 32'(level), 32'd0);
        check("bounce_count", 32'(press_count), 32'd1);

        // Short press: release ten cycles after press, no long press
        snap = long_seen;
        btn = 1'b1;
        run_until(0, 30, lat);
        check("short_press_latency", 32'(lat), 32'(D + 2));
        repeat (10 - lat) tick();
        btn = 1'b0;
        run_until(1, 30, lat);
        gap = (10 - (D + 2)) + lat;
        check("short_gap", 32'(gap), 32'd10);
        check("short_no_long", 32'(long_seen), 32'(snap));
        repeat (10) tick();

        // Wrap: 256 presses from a fresh reset bring the count back to 0
        rst = 1'b1; tick(); rst = 1'b0;
        snap = press_seen;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1; repeat (8) tick();
            btn = 1'b0; repeat (8) tick();
        end
        repeat (6) tick();
        check("wrap_strobes", 32'(press_seen - snap), 32'd256);
        check("wrap_count", 32'(press_count), 32'd0);

        // Reset while held high: no release, press re-qualifies afterwards
        btn = 1'b1;
        run_until(0, 30, lat);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_no_release", 32'(released), 32'd0);
        rst = 1'b0;
        run_until(0, 30, lat);
        check("rst_repress_latency", 32'(lat), 32'(D + 2));
        check("rst_repress_count", 32'(press_count), 32'd1);
        btn = 1'b0;
        repeat (12) tick();

        // Random bounce traffic with occasional resets
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(15, 35));
            else                          len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat (len - 1) tick();
        end
        btn = 1'b0;
        repeat (20) tick();
        check("final_level", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
